decrypt_seq: RTL
================

Name: decrypt_seq

Overview:
Sequencer that owns the ports of the dual-port data memory during a decrypt pass. On `start` it walks a ciphertext region byte by byte. Each byte is XORed with the state of an internal Fibonacci LFSR, and the result is written to a destination region. It sits between top-level control and the data memory, driving the memory's read address, write address, write data and write enable. It relies on the memory's combinational read and clocked write.

Parameters:
W, 8, data width in bits; matches the memory data width
byte_count, 256, memory depth; address width AW = $clog2(byte_count)
LFSR_W, 6, LFSR width in bits; must satisfy 2 <= LFSR_W <= W

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a pass; sampled only in IDLE
src_base  input  AW  first ciphertext address
dst_base  input  AW  first plaintext address
msg_len  input  AW  byte count of the pass; 0 means empty pass
taps  input  LFSR_W  feedback tap mask
seed  input  LFSR_W  initial LFSR state
mem_rdata  input  W  memory data_out, combinational from mem_raddr
mem_raddr  output  AW  memory read pointer
mem_waddr  output  AW  memory write pointer
mem_wdata  output  W  memory data_in
mem_we  output  1  memory write enable
busy  output  1  high in LOAD and RUN
done  output  1  one-cycle pulse in DONE

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Reset dominates every other input.
- Reset state:
  - state = IDLE; idx = 0; lfsr = 0; latched src, dst and len = 0.
  - busy = 0; done = 0; mem_we = 0.
  - mem_raddr, mem_waddr and mem_wdata = 0 whenever not in RUN.
- State machine (4 states):
  - IDLE: start=1 at an edge -> LOAD. The block latches src_base, dst_base, msg_len, taps and seed at that same edge.
  - LOAD (1 cycle): idx <= 0; lfsr <= latched seed. Next state is DONE if latched len == 0, else RUN.
  - RUN (exactly len cycles): drives the following combinationally each cycle:
    - mem_raddr = src + idx
    - mem_waddr = dst + idx
    - mem_wdata = mem_rdata ^ {{(W-LFSR_W){1'b0}}, lfsr}
    - mem_we = 1
  - RUN edge updates: idx <= idx+1; lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & taps)}. When idx == len-1 the next state is DONE.
  - DONE (1 cycle): done = 1, busy = 0, mem_we = 0 -> IDLE.
- Latency: start at edge k gives the first write at edge k+2, the last write at edge k+1+len, and done high in the cycle after edge k+1+len. Total start-to-done is len+2 cycles (2 cycles for len = 0).
- Address arithmetic: addresses are AW bits wide and wrap modulo byte_count, so 0xFF+1 = 0x00 with defaults. idx is AW bits wide; the maximum pass length is byte_count-1.
- Overlap:
  - src == dst (in place) is legal. Each byte is read combinationally, then written at the same edge.
  - Overlap with dst > src is not protected: later reads see already-decrypted data. This is documented behaviour, not an error.
- start while busy or in DONE is ignored; no queuing.
- Input changes after the LOAD edge have no effect on the pass in progress.
- seed = 0 is legal. The LFSR stays 0 and the output equals the ciphertext.
- Reset mid-pass: the block returns to IDLE on that edge. Bytes already written remain in memory. No write occurs at the reset edge or after it. done is not pulsed.
- No write ever occurs outside the RUN state.

Test Plan:
1. Basic decrypt. Preload mem[0x00..0x03] = 41,42,44,48. Drive taps=6'h30, seed=6'h01, src=0x00, dst=0x40, len=4, pulse start. Required: keystream 01,02,04,08; mem[0x40..0x43] = 40,40,40,40; mem_we high exactly 4 cycles; done pulses once, 6 cycles after the start edge.
2. Empty pass. len=0 -> mem_we never asserts; busy high 1 cycle (LOAD); done pulses in cycle 2; memory unchanged.
3. Wrap. src=0xFE, dst=0xFE, len=4, seed=0 -> reads and writes at FE, FF, 00, 01 in that order; data is unchanged (in place, zero key); mem_raddr never exceeds 0xFF.
4. Start ignored. A second start pulse asserted in the middle of RUN of a len=8 pass -> exactly 8 writes and 1 done pulse; the second start has no effect.
5. Reset mid-pass. Assert reset at the edge after the 2nd write of a len=6 pass -> only 2 destination bytes are modified; busy, done and mem_we = 0 from that edge onward; the next start runs a clean pass from the new seed.
6. Live input change. Change src_base, taps and seed during RUN -> written data and addresses match the values latched at the start edge.

Source files
------------

// File: rtl/decrypt_seq_if.sv
// Data-memory port bundle: the sequencer drives the pointers, write data and write enable;
// the memory returns read data combinationally from mem_raddr.
interface decrypt_seq_if #(
  parameter int W  = 8,
  parameter int AW = 8
);
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;
  logic          mem_we;
  logic [W-1:0]  mem_rdata;

  modport master (
    output mem_raddr, mem_waddr, mem_wdata, mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_raddr, mem_waddr, mem_wdata, mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/decrypt_seq.sv
// Decrypt pass sequencer: XORs each source byte with a Fibonacci LFSR keystream into the destination.
// Start-to-done is len+2 cycles; start is accepted only in IDLE and ignored otherwise (no queuing).
module decrypt_seq #(
  parameter int W          = 8,
  parameter int byte_count = 256,
  parameter int LFSR_W     = 6,
  localparam int AW        = $clog2(byte_count)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     src_base,
  input  logic [AW-1:0]     dst_base,
  input  logic [AW-1:0]     msg_len,
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] seed,
  decrypt_seq_if.master     mem,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     src;
  logic [AW-1:0]     dst;
  logic [AW-1:0]     len;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] taps_q;
  logic [LFSR_W-1:0] seed_q;
  logic              last;

  assign last = (idx == len - AW'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      lfsr   <= '0;
      src    <= '0;
      dst    <= '0;
      len    <= '0;
      taps_q <= '0;
      seed_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src    <= src_base;
            dst    <= dst_base;
            len    <= msg_len;
            taps_q <= taps;
            seed_q <= seed;
          end
        end
        LOAD: begin
          idx  <= '0;
          lfsr <= seed_q;
        end
        RUN: begin
          idx  <= idx + AW'(1);
          lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & taps_q)};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    mem.mem_raddr = '0;
    mem.mem_waddr = '0;
    mem.mem_wdata = '0;
    mem.mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = (len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy          = 1'b1;
        mem.mem_raddr = src + idx;
        mem.mem_waddr = dst + idx;
        mem.mem_wdata = mem.mem_rdata ^ W'(lfsr);
        // A reset landing on this edge must not commit the byte in flight.
        mem.mem_we    = ~reset;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
